// File: rtl/c2_pkg.sv
// ----------------------------------------------------------------------------
// c2_pkg
//   Definitions shared by the C2 debug blocks: the byte codes exchanged with
//   the C2 arbiter, the default host command bytes used by the debug
//   sequencer, and the dump reason encoding that travels with every dump.
//   No ports; imported with `import c2_pkg::*;`.
// ----------------------------------------------------------------------------
package c2_pkg;

    // Command bytes recognised by the C2 arbiter.
    localparam logic [7:0] C2_ARB_CMD_1C = 8'h1C;
    localparam logic [7:0] C2_ARB_CMD_1D = 8'h1D;
    localparam logic [7:0] C2_ARB_CMD_CE = 8'hCE;
    localparam logic [7:0] C2_ARB_CMD_DE = 8'hDE;

    // Default host bytes for the debug sequencer step session.
    localparam logic [7:0] CMD_STEP_DEFAULT  = 8'h5E;
    localparam logic [7:0] CMD_ABORT_DEFAULT = 8'hAB;

    // Why a dump was triggered; reported to the dumping unit.
    typedef enum logic [1:0] {
        DUMP_STEP    = 2'd0,
        DUMP_HALT    = 2'd1,
        DUMP_TIMEOUT = 2'd2
    } dump_reason_t;

endpackage : c2_pkg

// File: rtl/dbg_cycle_counter.sv
// ----------------------------------------------------------------------------
// dbg_cycle_counter
//   32-bit saturating count of enabled core cycles in a debug session, plus
//   the watchdog compare used in continuous mode.
//
//   Ports:
//     clk_i      in   clock
//     rst_ni     in   asynchronous active-low reset (count -> 0)
//     clr_i      in   synchronous clear, wins over en_i
//     en_i       in   count this cycle
//     count_o    out  current count (saturates at 32'hFFFF_FFFF)
//     wdt_hit_o  out  count_o == WDT_CYCLES-1
// ----------------------------------------------------------------------------
module dbg_cycle_counter #(
    parameter int unsigned WDT_CYCLES = 1048576
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] count_o,
    output logic        wdt_hit_o
);

    localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);

    logic [31:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o   = count_q;
    assign wdt_hit_o = (count_q == WDT_LAST);

endmodule : dbg_cycle_counter

// File: rtl/debug_sequencer.sv
// ----------------------------------------------------------------------------
// debug_sequencer
//   Runs the core while the C2 arbiter holds the debug grant, either freely
//   (continuous mode, guarded by a watchdog) or one cycle per host STEP byte.
//   After each step, a halt or a watchdog expiry the dumping unit is started;
//   once a session ends done_o is pulsed back to the arbiter.
//
//   Ports:
//     clk_i            in   clock
//     rst_ni           in   asynchronous active-low reset
//     grant_i          in   debug grant level from the arbiter
//     exec_mode_i      in   0 = step, 1 = continuous
//     uart_rx_data_i   in   host byte
//     uart_rx_ready_i  in   one-cycle strobe, uart_rx_data_i valid
//     core_halted_i    in   core has retired a halt instruction
//     core_en_o        out  core pipeline advances this cycle
//     dump_start_o     out  one-cycle pulse to the dumping unit
//     dump_reason_o    out  STEP / HALT / TIMEOUT, valid through the dump
//     dump_done_i      in   one-cycle pulse, dump transmitted
//     cycle_count_o    out  enabled core cycles this session (saturating)
//     done_o           out  one-cycle pulse, session over
//
//   All outputs are decoded from registers only.
// ----------------------------------------------------------------------------
module debug_sequencer
    import c2_pkg::*;
#(
    parameter int unsigned WDT_CYCLES = 1048576,
    parameter logic [7:0]  CMD_STEP   = CMD_STEP_DEFAULT,
    parameter logic [7:0]  CMD_ABORT  = CMD_ABORT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        grant_i,
    input  logic        exec_mode_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_ready_i,
    input  logic        core_halted_i,
    output logic        core_en_o,
    output logic        dump_start_o,
    output logic [1:0]  dump_reason_o,
    input  logic        dump_done_i,
    output logic [31:0] cycle_count_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_WAIT_CMD  = 3'd2,
        S_STEP      = 3'd3,
        S_DUMP_REQ  = 3'd4,
        S_DUMP_WAIT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t       state_q, state_d;
    // Holds the pending reason on entry to S_DUMP_REQ and the final reason
    // from then until the dump is acknowledged.
    dump_reason_t reason_q, reason_d;

    logic         cnt_clr;
    logic         wdt_hit;

    dbg_cycle_counter #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_cycle_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (cnt_clr),
        .en_i      (core_en_o),
        .count_o   (cycle_count_o),
        .wdt_hit_o (wdt_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            reason_q <= DUMP_STEP;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        reason_d     = reason_q;
        cnt_clr      = 1'b0;
        core_en_o    = 1'b0;
        dump_start_o = 1'b0;
        done_o       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_i) begin
                    cnt_clr = 1'b1;
                    state_d = exec_mode_i ? S_RUN : S_WAIT_CMD;
                end
            end

            S_RUN: begin
                core_en_o = 1'b1;
                if (core_halted_i) begin
                    reason_d = DUMP_HALT;
                    state_d  = S_DUMP_REQ;
                end else if (wdt_hit) begin
                    reason_d = DUMP_TIMEOUT;
                    state_d  = S_DUMP_REQ;
                end
            end

            S_WAIT_CMD: begin
                if (uart_rx_ready_i) begin
                    if (uart_rx_data_i == CMD_STEP) begin
                        // A halted core cannot step; report the halt directly.
                        if (core_halted_i) begin
                            reason_d = DUMP_HALT;
                            state_d  = S_DUMP_REQ;
                        end else begin
                            state_d  = S_STEP;
                        end
                    end else if (uart_rx_data_i == CMD_ABORT) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_STEP: begin
                core_en_o = 1'b1;
                reason_d  = DUMP_STEP;
                state_d   = S_DUMP_REQ;
            end

            S_DUMP_REQ: begin
                dump_start_o = 1'b1;
                // The stepped instruction may itself have been the halt.
                if ((reason_q == DUMP_STEP) && core_halted_i) begin
                    reason_d = DUMP_HALT;
                end
                state_d = S_DUMP_WAIT;
            end

            S_DUMP_WAIT: begin
                if (dump_done_i) begin
                    state_d = (reason_q == DUMP_STEP) ? S_WAIT_CMD : S_DONE;
                end
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Losing the grant abandons the session from any active state.
        if ((state_q != S_IDLE) && !grant_i) begin
            state_d = S_IDLE;
        end

        // The reason reads as STEP (0) whenever the sequencer is idle.
        if (state_d == S_IDLE) begin
            reason_d = DUMP_STEP;
        end
    end

    assign dump_reason_o = reason_q;

endmodule : debug_sequencer
